// File: rtl/mvm_result_collector.sv
// mvm_result_collector: captures the four-element y vector streamed by the
// matrix-vector multiplier after each done rise, reports its signed maximum
// and drains it through a valid/ready port with y[3] marked as last.
// Optional build macro MVM_RELU_EN clamps negative samples to zero before
// they are stored; the maximum is then taken over the clamped values.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a rise on mvm_done
// CAPTURE | storing y[cap_cnt] from mvm_data on each of four edges
// DRAIN   | presenting y[drain_idx] on out_data until the y[3] handshake

module mvm_result_collector (
    input  logic               clk,
    input  logic               reset,
    input  logic               mvm_done,
    input  logic signed [15:0] mvm_data,
    output logic signed [15:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic signed [15:0] max_val,
    output logic [1:0]         max_idx,
    output logic               vec_valid,
    output logic               overrun,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t             state_q;
    logic               done_q;
    logic [1:0]         cap_cnt_q;
    logic [1:0]         drain_idx_q;
    logic signed [15:0] y_q [4];
    logic signed [15:0] max_val_q;
    logic [1:0]         max_idx_q;
    logic               vec_valid_q;
    logic               overrun_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic signed [15:0] out_data_q;

    logic               rise;
    logic               handshake;
    logic               final_xfer;
    logic signed [15:0] stored_val;
    logic signed [15:0] cand [4];
    logic signed [15:0] max_val_d;
    logic [1:0]         max_idx_d;

    assign rise       = mvm_done & ~done_q;
    assign handshake  = out_valid_q & out_ready;
    assign final_xfer = handshake & (drain_idx_q == 2'd3);

    // Value actually written into y: optionally rectified sample.
    always_comb begin
`ifdef MVM_RELU_EN
        stored_val = mvm_data[15] ? 16'sd0 : mvm_data;
`else
        stored_val = mvm_data;
`endif
    end

    // Signed maximum over y[0..2] plus the sample being stored as y[3];
    // strict compare keeps the lowest index on ties.
    always_comb begin
        cand[0]   = y_q[0];
        cand[1]   = y_q[1];
        cand[2]   = y_q[2];
        cand[3]   = stored_val;
        max_val_d = cand[0];
        max_idx_d = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (cand[i] > max_val_d) begin
                max_val_d = cand[i];
                max_idx_d = 2'(i);
            end
        end
    end

    // Sequencer: capture, max/report, and drain with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            cap_cnt_q   <= 2'd0;
            drain_idx_q <= 2'd0;
            for (int i = 0; i < 4; i++) y_q[i] <= 16'sd0;
            max_val_q   <= 16'sd0;
            max_idx_q   <= 2'd0;
            vec_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 16'sd0;
        end else begin
            done_q      <= mvm_done;
            vec_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q   <= CAPTURE;
                        cap_cnt_q <= 2'd0;
                    end
                end
                CAPTURE: begin
                    y_q[cap_cnt_q] <= stored_val;
                    if (rise) overrun_q <= 1'b1;
                    if (cap_cnt_q == 2'd3) begin
                        state_q     <= DRAIN;
                        drain_idx_q <= 2'd0;
                        max_val_q   <= max_val_d;
                        max_idx_q   <= max_idx_d;
                        vec_valid_q <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        out_data_q  <= y_q[0];
                    end else begin
                        cap_cnt_q <= cap_cnt_q + 2'd1;
                    end
                end
                DRAIN: begin
                    if (rise && !final_xfer) overrun_q <= 1'b1;
                    if (handshake) begin
                        if (drain_idx_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= 16'sd0;
                            if (rise) begin
                                state_q   <= CAPTURE;
                                cap_cnt_q <= 2'd0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            drain_idx_q <= drain_idx_q + 2'd1;
                            out_data_q  <= y_q[drain_idx_q + 2'd1];
                            out_last_q  <= (drain_idx_q == 2'd2);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign max_val   = max_val_q;
    assign max_idx   = max_idx_q;
    assign vec_valid = vec_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mvm_result_collector.sv
// Directed scoreboard bench for mvm_result_collector.
module tb_mvm_result_collector;

    logic               clk = 1'b0;
    logic               reset;
    logic               mvm_done;
    logic signed [15:0] mvm_data;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic signed [15:0] max_val;
    logic [1:0]         max_idx;
    logic               vec_valid;
    logic               overrun;
    logic               busy;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic               prev_stall = 1'b0;
    logic               prev_vv    = 1'b0;
    logic signed [15:0] prev_data  = 16'sd0;

    mvm_result_collector dut (
        .clk       (clk),
        .reset     (reset),
        .mvm_done  (mvm_done),
        .mvm_data  (mvm_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .max_val   (max_val),
        .max_idx   (max_idx),
        .vec_valid (vec_valid),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall stability
    // and the single-cycle width of vec_valid.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_vv    = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(prev_data));
            end
            if (prev_vv) chk("vec_valid_pulse", int'(vec_valid), 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0d, expected no transfer", out_data);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_data", int'(out_data), mon_e.data);
                    chk("out_last", int'(out_last), int'(mon_e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_vv    = vec_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v, input bit last);
        exp_t e;
`ifdef MVM_RELU_EN
        e.data = (v < 0) ? 0 : v;
`else
        e.data = v;
`endif
        e.last = last;
        q.push_back(e);
    endtask

    // Caller has set mvm_done=1; the next edge samples the rise.
    task automatic feed(input int v0, input int v1, input int v2, input int v3,
                        input int emax, input int eidx);
        push_exp(v0, 1'b0);
        push_exp(v1, 1'b0);
        push_exp(v2, 1'b0);
        push_exp(v3, 1'b1);
        tick(); mvm_done = 1'b0; mvm_data = 16'(v0);
        tick(); mvm_data = 16'(v1);
        tick(); mvm_data = 16'(v2);
        tick(); mvm_data = 16'(v3);
        tick();
        chk("vec_valid", int'(vec_valid), 1);
        chk("max_val", int'(max_val), emax);
        chk("max_idx", int'(max_idx), eidx);
        chk("first_valid", int'(out_valid), 1);
        chk("busy_drain", int'(busy), 1);
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 60; k++) begin
            if (!busy) break;
            tick();
        end
        chk({nm, "_idle"}, int'(busy), 0);
        chk({nm, "_valid_low"}, int'(out_valid), 0);
        chk({nm, "_queue_empty"}, q.size(), 0);
    endtask

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        reset     = 1'b1;
        mvm_done  = 1'b0;
        mvm_data  = 16'sd0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_max_val", int'(max_val), 0);
        chk("rst_max_idx", int'(max_idx), 0);
        chk("rst_vec_valid", int'(vec_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        // Basic
        out_ready = 1'b1;
        mvm_done  = 1'b1;
        feed(38, 62, 86, 110, 110, 3);
        wait_idle("basic");

        // Backpressure 1,0,0,1,...
        out_ready = 1'b0;
        mvm_done  = 1'b1;
        feed(38, 62, 86, 110, 110, 3);
        for (int k = 0; k < 60; k++) begin
            out_ready = pat[k % 4];
            tick();
            if (!busy) break;
        end
        wait_idle("backpressure");

        // Negatives and tie
        out_ready = 1'b1;
        mvm_done  = 1'b1;
        feed(-5, 7, 7, -300, 7, 1);
        wait_idle("neg_tie");

        // Overrun: second rise while stalled in DRAIN
        chk("overrun_before", int'(overrun), 0);
        out_ready = 1'b0;
        mvm_done  = 1'b1;
        feed(38, 62, 86, 110, 110, 3);
        mvm_done = 1'b1;
        tick();
        mvm_done = 1'b0;
        mvm_data = 16'sd999;
        tick();
        chk("overrun_set", int'(overrun), 1);
        tick();
        tick();
        out_ready = 1'b1;
        wait_idle("overrun");
        repeat (6) tick();
        chk("overrun_no_second_vec", int'(busy), 0);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset mid-DRAIN after two transfers
        out_ready = 1'b0;
        mvm_done  = 1'b1;
        feed(11, 22, 33, 44, 44, 3);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        q.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_out_last", int'(out_last), 0);
        chk("midrst_max_val", int'(max_val), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_busy", int'(busy), 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("midrst_no_xfer", int'(out_valid), 0);

        // Back-to-back: second rise lands on the y[3] handshake
        mvm_done = 1'b1;
        feed(10, 20, 30, 40, 40, 3);
        tick();
        tick();
        tick();
        mvm_done = 1'b1;
        feed(1, 2, 3, 4, 4, 3);
        wait_idle("b2b");
        chk("b2b_no_overrun", int'(overrun), 0);

        // mvm_done already high when reset releases counts as a rise
        mvm_done = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        feed(5, -1, 5, 3, 5, 0);
        wait_idle("done_after_reset");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
